// File: rtl/config_byte_loader.sv
// Assembles 9-byte {addr, data, xor} frames from a byte stream and issues
// one-cycle config writes to the switch box, with a post-write quiet gap.
module config_byte_loader #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [31:0]      config_addr,
  output logic [31:0]      config_data,
  output logic             config_en,
  output logic             chk_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    COLLECT,
    WRITE,
    GAP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  idx;
  logic [7:0]  xor_acc;
  logic [63:0] shadow;
  logic [3:0]  gap_cnt;

  logic accept;
  logic last_byte;
  logic sum_ok;
  logic commit;

  // Reset also gates the handshake and strobe so nothing leaks out while held.
  assign in_ready  = (state == COLLECT) && !abort && !reset;
  assign config_en = (state == WRITE) && !reset;
  assign accept    = in_valid && in_ready;
  assign last_byte = (idx == 4'd8);
  assign sum_ok    = ((xor_acc ^ in_data) == 8'h00);
  assign commit    = accept && last_byte && sum_ok;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    case (state)
      COLLECT: if (commit) state_next = WRITE;
      WRITE:   state_next = (GAP_CYCLES > 0) ? GAP : COLLECT;
      GAP:     if (gap_cnt == 4'd0) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= 4'd0;
    end else if (state == WRITE) begin
      gap_cnt <= 4'(GAP_CYCLES - 1);
    end else if (state == GAP && gap_cnt != 4'd0) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= 4'd0;
      xor_acc     <= 8'h00;
      shadow      <= 64'h0;
      config_addr <= 32'h0;
      config_data <= 32'h0;
      chk_err     <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else if (state == COLLECT && abort) begin
      idx     <= 4'd0;
      xor_acc <= 8'h00;
    end else if (accept) begin
      if (last_byte) begin
        idx     <= 4'd0;
        xor_acc <= 8'h00;
        // Counters bump on the accepting edge so they are current during WRITE.
        if (sum_ok) begin
          config_addr <= shadow[63:32];
          config_data <= shadow[31:0];
          if (frame_count != '1) frame_count <= frame_count + 1'b1;
        end else begin
          chk_err <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end else begin
        shadow  <= {shadow[55:0], in_data};
        idx     <= idx + 4'd1;
        xor_acc <= xor_acc ^ in_data;
      end
    end
  end

endmodule
